wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have one parameter: SP_INIT, default 32'h0, reset value of x2.
REQ-002 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 rdy_in  input  1  global ready; 0 freezes all state.
REQ-005 wb_rd_addr  input  5  destination register from the writeback pipeline register.
REQ-006 wb_rd_val  input  32  writeback data.
REQ-007 wb_ins_type  input  7  RISC-V opcode of the retiring instruction.
REQ-008 iss_valid  input  1  decode issues an instruction this cycle.
REQ-009 iss_rd_addr  input  5  destination of the issued instruction.
REQ-010 rs1_addr, rs2_addr  input  5 each  read-port addresses.
REQ-011 rs1_val, rs2_val  output  32 each  read data (combinational).
REQ-012 rs1_busy, rs2_busy  output  1 each  operand has a pending write that is not yet available.
REQ-013 stall_req  output  1  rs1_busy OR rs2_busy.

Function
REQ-014 Storage SHALL be 32 x 32-bit registers; x0 SHALL read 0 and ignore writes.
REQ-015 wb_we SHALL be 1 iff wb_ins_type is one of LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP 0110011, and wb_rd_addr != 0.
REQ-016 Stores, branches and all other opcodes SHALL NOT write; 0010011 with rd=0 (bubble) SHALL NOT write.
REQ-017 On a rising edge with rdy_in=1 and wb_we=1, regs[wb_rd_addr] SHALL take wb_rd_val; write latency is 1 cycle.
REQ-018 Read bypass: if rsN_addr == wb_rd_addr and wb_we=1, rsN_val SHALL equal wb_rd_val in the same cycle; otherwise regs[rsN_addr]; rs=0 SHALL return 0.
REQ-019 Scoreboard: 32-bit busy vector; bit 0 SHALL always be 0.
REQ-020 At an edge with rdy_in=1, iss_valid=1 and iss_rd_addr != 0, busy[iss_rd_addr] SHALL set.
REQ-021 At an edge with rdy_in=1 and wb_we=1, busy[wb_rd_addr] SHALL clear.
REQ-022 Set and clear of the same index in one cycle: set SHALL win (the newer producer).
REQ-023 rsN_busy SHALL be busy[rsN_addr] AND NOT (wb_we AND wb_rd_addr == rsN_addr); rs=0 SHALL never be busy.
REQ-024 Counter of outstanding writes (6-bit, 0..31) SHALL increment on set of a clear bit and decrement on clear of a set bit; net 0 when both occur on different bits; it SHALL NOT wrap and is observable internally only.
REQ-025 rdy_in=0 SHALL block register writes, scoreboard updates and counter updates; combinational outputs SHALL still follow inputs.

Reset
REQ-026 While rst_in=1 asynchronously: all registers SHALL be 0 except x2 = SP_INIT; busy vector 0; counter 0.
REQ-027 After reset: rs1_val = rs2_val = 0 for any address except 2; rs1_busy = rs2_busy = stall_req = 0.
REQ-028 Reset asserted mid-operation SHALL discard a same-cycle write and clear pending busy bits immediately, without waiting for a clock edge.

Verification
REQ-029 Reset with SP_INIT=32'h0001_0000, read rs1=2, rs2=5 -> rs1_val=0x00010000, rs2_val=0, stall_req=0.
REQ-030 wb_ins_type=0110011, rd=7, val=0xDEADBEEF, rs1=7 in the same cycle -> rs1_val=0xDEADBEEF (bypass); next cycle with no writeback -> still 0xDEADBEEF.
REQ-031 wb_ins_type=0100011 (store), rd=7, val=0x1234; and 0010011 with rd=0 -> x7 unchanged, x0 reads 0.
REQ-032 Issue rd=5; next cycle rs1=5 -> rs1_busy=1, stall_req=1; LOAD writeback rd=5 val=0x55 -> same cycle rs1_busy=0, rs1_val=0x55; following cycle busy[5]=0.
REQ-033 Same cycle: issue rd=9 and writeback rd=9 -> busy[9]=1 afterwards; with rdy_in=0, issue rd=3 and writeback rd=3 val=0x1 -> x3 and busy[3] unchanged.
REQ-034 Issue rd=4, assert rst_in between edges -> rs1=4 busy drops immediately, and x4 reads 0 with the same timing.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: 32x32 RISC-V integer register file with writeback bypass and a busy scoreboard.
module wb_regfile #(
  parameter logic [31:0] SP_INIT = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_rd_val,
  input  logic [6:0]  wb_ins_type,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd_addr,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        stall_req
);
  logic [31:0] regs [32];
  logic [31:0] busy, busy_nxt;
  logic [5:0]  cnt;
  logic        wb_we, set_en, inc, dec, hit1, hit2;
  always_comb begin
    wb_we = (wb_ins_type inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                 7'b0000011, 7'b0010011, 7'b0110011}) && wb_rd_addr != 5'd0;
    set_en = iss_valid && iss_rd_addr != 5'd0;
    hit1 = wb_we && wb_rd_addr == rs1_addr;
    hit2 = wb_we && wb_rd_addr == rs2_addr;
    rs1_val = rs1_addr == 5'd0 ? 32'd0 : hit1 ? wb_rd_val : regs[rs1_addr];
    rs2_val = rs2_addr == 5'd0 ? 32'd0 : hit2 ? wb_rd_val : regs[rs2_addr];
    rs1_busy = busy[rs1_addr] && !hit1;
    rs2_busy = busy[rs2_addr] && !hit2;
    stall_req = rs1_busy || rs2_busy;
  end
  // set is applied after clear so a new producer wins over a retiring one
  always_comb begin
    busy_nxt = busy;
    if (wb_we) busy_nxt[wb_rd_addr] = 1'b0;
    if (set_en) busy_nxt[iss_rd_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
    inc = set_en && !busy[iss_rd_addr];
    dec = wb_we && busy[wb_rd_addr] && !(set_en && iss_rd_addr == wb_rd_addr);
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 2) ? SP_INIT : 32'd0;
      busy <= '0;
      cnt <= '0;
    end else if (rdy_in) begin
      if (wb_we) regs[wb_rd_addr] <= wb_rd_val;
      busy <= busy_nxt;
      cnt <= cnt + {5'd0, inc} - {5'd0, dec};
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: random and directed stimulus with a queue-based scoreboard against an array model.
module tb_wb_regfile;
  localparam logic [31:0] SP = 32'h0001_0000;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
    OP_JALR = 7'b1100111, OP_LOAD = 7'b0000011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011,
    OP_STORE = 7'b0100011, OP_BR = 7'b1100011;

  logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
  logic [4:0]  wb_rd_addr = '0, iss_rd_addr = '0, rs1_addr = '0, rs2_addr = '0;
  logic [31:0] wb_rd_val = '0;
  logic [6:0]  wb_ins_type = OP_STORE;
  logic        iss_valid = 1'b0;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_busy, rs2_busy, stall_req;

  wb_regfile #(.SP_INIT(SP)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .wb_rd_addr(wb_rd_addr), .wb_rd_val(wb_rd_val), .wb_ins_type(wb_ins_type),
    .iss_valid(iss_valid), .iss_rd_addr(iss_rd_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .stall_req(stall_req)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string       tag;
    logic [31:0] v1, v2;
    logic        b1, b2, st;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  int          n_checks = 0, n_fail = 0;

  function automatic bit writes(input logic [6:0] op, input logic [4:0] rd);
    return rd != 0 && (op == OP_LUI || op == OP_AUIPC || op == OP_JAL || op == OP_JALR ||
                       op == OP_LOAD || op == OP_IMM || op == OP_OP);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit we, input logic [4:0] rd,
                                         input logic [31:0] v);
    if (a == 0) return 32'd0;
    if (we && rd == a) return v;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = (i == 2) ? SP : 32'd0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic check(input string tag, input string what, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", tag, what, got, want);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, compared mid-cycle away from the clock edge
  always @(negedge clk_in) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, "rs1_val", rs1_val, e.v1);
      check(e.tag, "rs2_val", rs2_val, e.v2);
      check(e.tag, "rs1_busy", {31'd0, rs1_busy}, {31'd0, e.b1});
      check(e.tag, "rs2_busy", {31'd0, rs2_busy}, {31'd0, e.b2});
      check(e.tag, "stall_req", {31'd0, stall_req}, {31'd0, e.st});
    end
  end

  task automatic push_exp(input string tag, input bit we);
    exp_t e;
    e.tag = tag;
    e.v1 = m_read(rs1_addr, we, wb_rd_addr, wb_rd_val);
    e.v2 = m_read(rs2_addr, we, wb_rd_addr, wb_rd_val);
    e.b1 = rs1_addr != 0 && m_busy[rs1_addr] && !(we && wb_rd_addr == rs1_addr);
    e.b2 = rs2_addr != 0 && m_busy[rs2_addr] && !(we && wb_rd_addr == rs2_addr);
    e.st = e.b1 || e.b2;
    sb.push_back(e);
  endtask

  // Called just after a rising edge: drive, predict, then let the edge commit the model
  task automatic drive(input string tag, input bit rdy, input logic [6:0] op, input logic [4:0] rd,
                       input logic [31:0] val, input bit iv, input logic [4:0] ird,
                       input logic [4:0] a1, input logic [4:0] a2);
    bit we;
    rdy_in = rdy; wb_ins_type = op; wb_rd_addr = rd; wb_rd_val = val;
    iss_valid = iv; iss_rd_addr = ird; rs1_addr = a1; rs2_addr = a2;
    we = writes(op, rd);
    push_exp(tag, we);
    @(posedge clk_in);
    if (rdy) begin
      if (we) begin
        m_regs[rd] = val;
        m_busy[rd] = 1'b0;
      end
      if (iv && ird != 0) m_busy[ird] = 1'b1;
    end
    #1;
  endtask

  // Reset raised between edges alongside a pending write that must be discarded
  task automatic do_reset(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    wb_ins_type = OP_LOAD; wb_rd_addr = 5'd6; wb_rd_val = 32'h66; iss_valid = 1'b1;
    iss_rd_addr = 5'd8; rs1_addr = a1; rs2_addr = a2; rdy_in = 1'b1;
    rst_in = 1'b1;
    model_reset();
    #1;
    push_exp(tag, a1 == 6 || a2 == 6);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  logic [6:0] ops [9] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP, OP_STORE, OP_BR};

  initial begin
    model_reset();
    @(posedge clk_in);
    #1;
    do_reset("reset", 5'd2, 5'd5);
    drive("rst_state", 1, OP_STORE, 0, 0, 0, 0, 5'd2, 5'd5);
    drive("rst_x6_dropped", 1, OP_STORE, 0, 0, 0, 0, 5'd6, 5'd8);
    drive("bypass", 1, OP_OP, 7, 32'hDEADBEEF, 0, 0, 5'd7, 5'd0);
    drive("after_write", 1, OP_STORE, 0, 0, 0, 0, 5'd7, 5'd0);
    drive("store", 1, OP_STORE, 7, 32'h1234, 0, 0, 5'd7, 5'd0);
    drive("bubble", 1, OP_IMM, 0, 32'h99, 0, 0, 5'd7, 5'd0);
    drive("x7_kept", 1, OP_BR, 7, 32'h77, 0, 0, 5'd7, 5'd0);
    drive("issue5", 1, OP_STORE, 0, 0, 1, 5, 5'd0, 5'd0);
    drive("busy5", 1, OP_STORE, 0, 0, 0, 0, 5'd5, 5'd0);
    drive("wb5_bypass", 1, OP_LOAD, 5, 32'h55, 0, 0, 5'd5, 5'd5);
    drive("busy5_clear", 1, OP_STORE, 0, 0, 0, 0, 5'd5, 5'd0);
    drive("issue_wb9", 1, OP_IMM, 9, 32'h9, 1, 9, 5'd0, 5'd0);
    drive("busy9_kept", 1, OP_STORE, 0, 0, 0, 0, 5'd9, 5'd9);
    drive("frozen3", 0, OP_LOAD, 3, 32'h1, 1, 3, 5'd0, 5'd0);
    drive("x3_unchanged", 1, OP_STORE, 0, 0, 0, 0, 5'd3, 5'd3);
    drive("write4", 1, OP_LUI, 4, 32'h44, 0, 0, 5'd0, 5'd0);
    drive("issue4", 1, OP_STORE, 0, 0, 1, 4, 5'd4, 5'd0);
    drive("busy4", 1, OP_STORE, 0, 0, 0, 0, 5'd4, 5'd4);
    do_reset("async_reset", 5'd4, 5'd4);
    drive("x4_cleared", 1, OP_STORE, 0, 0, 0, 0, 5'd4, 5'd6);
    for (int i = 0; i < 400; i++) begin
      logic [4:0] rd, a1, a2;
      logic [6:0] op;
      rd = 5'($urandom_range(0, 31));
      op = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      drive("random", $urandom_range(0, 7) != 0, op, rd, $urandom,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), a1, a2);
    end
    @(negedge clk_in);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
